// File: rtl/sme_param.sv
// Parametrised string-match engine: buffers a string and a pattern, then finds the leftmost match.
// Optional case-insensitive compare is enabled by defining SME_CASE_FOLD_EN (adds the nocase input).
module sme_param #(
    parameter int CHAR_W  = 8,
    parameter int MAX_STR = 32,
    parameter int MAX_PAT = 8,
    parameter int IDX_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              busy,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index
`ifdef SME_CASE_FOLD_EN
    ,
    input  logic              nocase
`endif
);

    localparam int SL_W = $clog2(MAX_STR + 1);
    localparam int PL_W = $clog2(MAX_PAT + 1);
    localparam int C_W  = $clog2(MAX_STR + MAX_PAT + 2);
    localparam int SA_W = (MAX_STR > 1) ? $clog2(MAX_STR) : 1;
    localparam int PA_W = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;

    localparam logic [CHAR_W-1:0] CH_CARET  = CHAR_W'(8'h5E);
    localparam logic [CHAR_W-1:0] CH_DOLLAR = CHAR_W'(8'h24);
    localparam logic [CHAR_W-1:0] CH_DOT    = CHAR_W'(8'h2E);
    localparam logic [CHAR_W-1:0] CH_SPACE  = CHAR_W'(8'h20);

    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

    state_t            state_q, state_d;
    logic [CHAR_W-1:0] str_mem_q [MAX_STR];
    logic [CHAR_W-1:0] str_mem_d [MAX_STR];
    logic [CHAR_W-1:0] pat_mem_q [MAX_PAT];
    logic [CHAR_W-1:0] pat_mem_d [MAX_PAT];
    logic [SL_W-1:0]   str_len_q, str_len_d;
    logic [PL_W-1:0]   pat_len_q, pat_len_d;
    logic              str_fresh_q, str_fresh_d;
    logic              pat_fresh_q, pat_fresh_d;
    logic [C_W-1:0]    cand_q, cand_d;
    logic [C_W-1:0]    k_q, k_d;
    logic              match_q, match_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
`ifdef SME_CASE_FOLD_EN
    logic              nocase_q, nocase_d;

    function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
        if (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A))
            return c | CHAR_W'(8'h20);
        return c;
    endfunction
`endif

    logic [C_W-1:0]    str_len_c, pat_len_c, last_idx, body_lo, body_len, pos;
    logic              anchor_start, anchor_end;
    logic [CHAR_W-1:0] s_char, p_char, prev_char;
    logic              start_ok, end_ok, char_eq, step_ok, give_up;

    // The body is the part of the pattern that consumes string characters;
    // a leading '^' and trailing '$' are positional checks only.
    always_comb begin
        str_len_c    = C_W'(str_len_q);
        pat_len_c    = C_W'(pat_len_q);
        last_idx     = pat_len_c - C_W'(1);
        anchor_start = (pat_len_q != '0) && (pat_mem_q[0] == CH_CARET);
        body_lo      = anchor_start ? C_W'(1) : '0;
        anchor_end   = (pat_len_q != '0) && (pat_mem_q[PA_W'(last_idx)] == CH_DOLLAR)
                       && (last_idx >= body_lo);
        body_len     = pat_len_c - body_lo - (anchor_end ? C_W'(1) : '0);
        pos          = cand_q + k_q;
        s_char       = str_mem_q[SA_W'(pos)];
        p_char       = pat_mem_q[PA_W'(body_lo + k_q)];
        prev_char    = str_mem_q[SA_W'(cand_q - C_W'(1))];
        start_ok     = !anchor_start || (cand_q == '0) || (prev_char == CH_SPACE);
        end_ok       = !anchor_end || (pos == str_len_c)
                       || ((pos < str_len_c) && (s_char == CH_SPACE));
`ifdef SME_CASE_FOLD_EN
        char_eq      = (p_char == CH_DOT) ||
                       (nocase_q ? (fold(s_char) == fold(p_char)) : (s_char == p_char));
`else
        char_eq      = (p_char == CH_DOT) || (s_char == p_char);
`endif
        step_ok      = ((k_q != '0) || start_ok) && ((k_q < body_len) ? char_eq : end_ok);
        give_up      = (str_len_q == '0) || (pat_len_q == '0) || (cand_q + body_len > str_len_c);
    end

    always_comb begin
        state_d     = state_q;
        str_mem_d   = str_mem_q;
        pat_mem_d   = pat_mem_q;
        str_len_d   = str_len_q;
        pat_len_d   = pat_len_q;
        str_fresh_d = str_fresh_q;
        pat_fresh_d = pat_fresh_q;
        cand_d      = cand_q;
        k_d         = k_q;
        match_d     = match_q;
        idx_d       = idx_q;
`ifdef SME_CASE_FOLD_EN
        nocase_d    = nocase_q;
`endif

        // Loads are accepted in every state except SEARCH; string wins a tie.
        if (state_q != SEARCH) begin
            if (isstring) begin
                if (str_fresh_q) begin
                    str_mem_d[0] = chardata;
                    str_len_d    = SL_W'(1);
                    str_fresh_d  = 1'b0;
                end else if (str_len_q < SL_W'(MAX_STR)) begin
                    str_mem_d[SA_W'(str_len_q)] = chardata;
                    str_len_d = str_len_q + 1'b1;
                end
            end else if (ispattern) begin
                if (pat_fresh_q) begin
                    pat_mem_d[0] = chardata;
                    pat_len_d    = PL_W'(1);
                    pat_fresh_d  = 1'b0;
                end else if (pat_len_q < PL_W'(MAX_PAT)) begin
                    pat_mem_d[PA_W'(pat_len_q)] = chardata;
                    pat_len_d = pat_len_q + 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (isstring || ispattern)
                    state_d = LOAD;
            end
            LOAD: begin
                if (!isstring && !ispattern) begin
                    state_d = SEARCH;
                    cand_d  = '0;
                    k_d     = '0;
`ifdef SME_CASE_FOLD_EN
                    nocase_d = nocase;
`endif
                end
            end
            SEARCH: begin
                if (give_up || step_ok && (k_q == body_len)) begin
                    state_d     = DONE;
                    match_d     = !give_up;
                    idx_d       = give_up ? '0 : IDX_W'(cand_q);
                    str_fresh_d = 1'b1;
                    pat_fresh_d = 1'b1;
                end else if (step_ok) begin
                    k_d = k_q + C_W'(1);
                end else begin
                    cand_d = cand_q + C_W'(1);
                    k_d    = '0;
                end
            end
            DONE: begin
                state_d = (isstring || ispattern) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            str_len_q   <= '0;
            pat_len_q   <= '0;
            str_fresh_q <= 1'b1;
            pat_fresh_q <= 1'b1;
            cand_q      <= '0;
            k_q         <= '0;
            match_q     <= 1'b0;
            idx_q       <= '0;
`ifdef SME_CASE_FOLD_EN
            nocase_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            str_len_q   <= str_len_d;
            pat_len_q   <= pat_len_d;
            str_fresh_q <= str_fresh_d;
            pat_fresh_q <= pat_fresh_d;
            cand_q      <= cand_d;
            k_q         <= k_d;
            match_q     <= match_d;
            idx_q       <= idx_d;
`ifdef SME_CASE_FOLD_EN
            nocase_q    <= nocase_d;
`endif
        end
    end

    // Buffer contents need no reset: only indices below the stored lengths are read.
    always_ff @(posedge clk) begin
        str_mem_q <= str_mem_d;
        pat_mem_q <= pat_mem_d;
    end

    assign busy        = (state_q == SEARCH);
    assign valid       = (state_q == DONE);
    assign match       = match_q;
    assign match_index = idx_q;

endmodule

// File: tb/tb_sme_param.sv
// Scoreboard bench for sme_param: directed string/pattern vectors with hand-computed results.
// Builds with or without SME_CASE_FOLD_EN.
module tb_sme_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       busy;
    logic       valid;
    logic       match;
    logic [4:0] match_index;
`ifdef SME_CASE_FOLD_EN
    logic       nocase;
`endif

    sme_param #(.CHAR_W(8), .MAX_STR(32), .MAX_PAT(8), .IDX_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .busy        (busy),
        .valid       (valid),
        .match       (match),
        .match_index (match_index)
`ifdef SME_CASE_FOLD_EN
        ,
        .nocase      (nocase)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         m;
        logic [4:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: every valid pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_valid: got valid with match=%0d idx=%0d, required no valid",
                         match, match_index);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (match !== e.m) begin
                    failures++;
                    $display("[TB] FAIL result_match: got %0d, required %0d", match, e.m);
                end
                checks++;
                if (match_index !== e.idx) begin
                    failures++;
                    $display("[TB] FAIL result_index: got %0d, required %0d", match_index, e.idx);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic driveChars(input string s, input bit as_str);
        for (int i = 0; i < s.len(); i++) begin
            chardata  = s[i];
            isstring  = as_str;
            ispattern = !as_str;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitBusy();
        int c = 0;
        while (busy !== 1'b1 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("busy_rise", {31'd0, busy}, 32'd1);
    endtask

    task automatic waitResult();
        int c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL result_timeout: got no valid after %0d cycles, required a valid", c);
            exp_q.delete();
        end
    endtask

    // Empty s keeps the stored string; poke drives string chars while busy.
    task automatic applyStimulus(input string s, input string p, input bit m,
                                 input logic [4:0] idx, input bit poke);
        exp_t  e;
        string pk = "xyz";
        e.m   = m;
        e.idx = idx;
        exp_q.push_back(e);
        driveChars(s, 1'b1);
        driveChars(p, 1'b0);
        isstring  = 1'b0;
        ispattern = 1'b0;
        if (poke) begin
            waitBusy();
            for (int i = 0; i < 3; i++) begin
                chardata = pk[i];
                isstring = 1'b1;
                @(posedge clk);
                #1;
            end
            isstring = 1'b0;
        end
        waitResult();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        string long_s;
        reset     = 1'b1;
        chardata  = 8'h00;
        isstring  = 1'b0;
        ispattern = 1'b0;
`ifdef SME_CASE_FOLD_EN
        nocase    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_valid", {31'd0, valid}, 32'd0);
        checkOutput("reset_match", {31'd0, match}, 32'd0);
        checkOutput("reset_index", {27'd0, match_index}, 32'd0);
        @(posedge clk);
        #1;

        applyStimulus("hello world", "wor", 1'b1, 5'd6, 1'b0);
        applyStimulus("", "^wor", 1'b1, 5'd6, 1'b0);
        applyStimulus("", "^orl", 1'b0, 5'd0, 1'b0);
        applyStimulus("abc abd", "ab.$", 1'b1, 5'd0, 1'b0);
        applyStimulus("", "bd$", 1'b1, 5'd5, 1'b0);
        applyStimulus("aaab", "aab", 1'b1, 5'd1, 1'b0);
        applyStimulus("x ab", "^ab", 1'b1, 5'd2, 1'b0);
        applyStimulus("a^b", "a^b", 1'b1, 5'd0, 1'b0);

        long_s = "";
        for (int i = 0; i < 32; i++) long_s = {long_s, "a"};
        long_s = {long_s, "xyzaaaaa"};
        applyStimulus(long_s, "xyz", 1'b0, 5'd0, 1'b1);
        applyStimulus("", "aaa", 1'b1, 5'd0, 1'b0);
        applyStimulus("", "a$", 1'b1, 5'd31, 1'b0);

        applyStimulus("abcdefghij", "cdefghijZZ", 1'b1, 5'd2, 1'b0);

        // Abort a running search with reset; no result may appear afterwards.
        driveChars("zz", 1'b0);
        ispattern = 1'b0;
        waitBusy();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_valid", {31'd0, valid}, 32'd0);
        checkOutput("abort_match", {31'd0, match}, 32'd0);
        checkOutput("abort_index", {27'd0, match_index}, 32'd0);
        repeat (20) @(posedge clk);
        #1;

        applyStimulus("abc", "", 1'b0, 5'd0, 1'b0);
        applyStimulus("", "c$", 1'b1, 5'd2, 1'b0);

`ifdef SME_CASE_FOLD_EN
        nocase = 1'b1;
        applyStimulus("Hello", "hEL", 1'b1, 5'd0, 1'b0);
        nocase = 1'b0;
        applyStimulus("Hello", "hEL", 1'b0, 5'd0, 1'b0);
`else
        applyStimulus("Hello", "hEL", 1'b0, 5'd0, 1'b0);
        applyStimulus("", "Hel", 1'b1, 5'd0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sme_param.md
Name: sme_param

Overview:
- Parametrised string-match engine, next generation of the team's serial pattern matcher.
- Buffers one string and one pattern, both delivered a character per cycle, then searches for the leftmost occurrence.
- Supports the '^', '$' and '.' metacharacters; character width, string depth and pattern depth are configurable.
- Adds a busy handshake and a fixed no-match result. A string is retained across multiple patterns.

Parameters:
- CHAR_W, 8: character width in bits.
- MAX_STR, 32: maximum stored string length, in characters.
- MAX_PAT, 8: maximum stored pattern length, in characters, metacharacters included.
- IDX_W, 5: width of match_index; must satisfy 2^IDX_W >= MAX_STR.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- chardata, in, CHAR_W: character for the current load cycle.
- isstring, in, 1: chardata is a string character.
- ispattern, in, 1: chardata is a pattern character.
- busy, out, 1: high while a search runs; loads are ignored while high.
- valid, out, 1: one-cycle pulse when a result is ready.
- match, out, 1: result flag; held until the next valid.
- match_index, out, IDX_W: 0-based string index of the match start; held until the next valid.

Behaviour:
- Reset: busy=0, valid=0, match=0, match_index=0, string length 0, pattern length 0, FSM in IDLE.
- Reset mid-search aborts the search; no valid is produced.
- FSM states: IDLE, LOAD, SEARCH, DONE.
- String load (isstring=1):
  - First string char after a valid, or after reset, clears the stored string; chars are appended at the next index.
  - Chars beyond MAX_STR are dropped.
  - isstring has priority over ispattern when both are high.
- Pattern load (ispattern=1):
  - First pattern char after a valid clears the stored pattern.
  - Chars beyond MAX_PAT are dropped.
  - Asserting isstring or ispattern moves IDLE to LOAD.
- LOAD -> SEARCH on the first cycle with isstring=0 and ispattern=0; busy rises that same edge.
- No new string since the last valid: the previous string is reused.
- Match semantics, with S the string of length L and P the pattern:
  - '^' (0x5E) as the first pattern char matches position 0 or any position immediately after a space (0x20).
  - '$' (0x24) as the last pattern char matches end of string or a position immediately before a space.
  - '.' (0x2E) matches exactly one string char of any value.
  - All other chars compare exactly.
  - '^' or '$' in any other pattern position is a literal.
- match_index is the index of the first string char consumed by the pattern; '^' itself consumes none. The leftmost match is reported.
- Search: one character comparison per cycle. On mismatch, restart at the candidate start + 1 with pattern index 0.
- Search aborts as no-match when the remaining string chars are fewer than the remaining non-anchor pattern chars.
- SEARCH -> DONE on a hit or an abort.
- DONE (one cycle): valid=1, match and match_index updated, busy=0; then -> IDLE.
- No-match result: match=0, match_index=0.
- Empty pattern or empty string: SEARCH lasts one cycle, then no-match.
- Latency from the last load char to valid: at most (MAX_STR+1)*MAX_PAT + 3 cycles.
- isstring or ispattern while busy=1 is ignored, with no buffer corruption.
- Arithmetic: all index counters are wide enough for MAX_STR+1 without wrap.

Optional Feature:
- Macro: SME_CASE_FOLD_EN.
- Defined:
  - Adds input port nocase (1 bit), sampled on the LOAD->SEARCH edge.
  - When nocase=1, ASCII letters compare case-insensitively: 0x41-0x5A and 0x61-0x7A are equal after folding.
  - Metacharacters are unaffected.
- Undefined: the port is absent and all comparisons are exact.

Test Plan:
- String "hello world", pattern "wor" -> valid pulse, match=1, match_index=6.
- Same string retained, pattern "^wor" -> match=1, index=6. Pattern "^orl" -> match=0, index=0.
- String "abc abd", pattern "ab.$" -> match=1, index=0. Pattern "bd$" -> match=1, index=5.
- String "aaab", pattern "aab" -> match=1, index=1 (restart-after-mismatch check).
- 40-char string with MAX_STR=32, pattern matching only at chars 33-35 -> match=0. Chars pulsed during busy do not change the next result.
- Reset asserted mid-search -> no valid pulse; all outputs 0 next cycle. With SME_CASE_FOLD_EN and nocase=1: "Hello", pattern "hEL" -> match=1, index=0.
